// File: rtl/iic_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iic_slave_pkg
//  Purpose  : Shared types and constants for the I2C target (iic_slave).
//             FSM state encoding, bit-counter width, bus level constants.
//  Revision : 1.0 - initial release
// ============================================================================
package iic_slave_pkg;

    // Bit counter covers the 8 data bits of one byte
    localparam int c_BIT_CNT_W = 3;

    // Last bit index in a byte, in counter width
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = 3'd7;

    // Bus level of an acknowledge / not-acknowledge bit
    localparam logic c_ACK  = 1'b0;
    localparam logic c_NACK = 1'b1;

    // SDA output-enable levels (open drain: 1 pulls the line low)
    localparam logic c_OE_PULL    = 1'b1;
    localparam logic c_OE_RELEASE = 1'b0;

    // Default 7-bit target address
    localparam logic [6:0] c_DEFAULT_ADDRESS = 7'b1001111;

    // Target state machine
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    // True when the upper seven bits of the first byte equal our address.
    // Address 0 (general call) can never match a non-zero ADDRESS, and
    // 10-bit header bytes (11110xx) are treated like any other mismatch.
    function automatic logic addr_match(input logic [7:0] first_byte,
                                        input logic [6:0] address);
        return (first_byte[7:1] == address);
    endfunction

endpackage : iic_slave_pkg
`default_nettype wire

// File: rtl/iic_slave_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : iic_edge_sync
//  Purpose  : Two-flop synchronizer plus one delayed copy for a single bus
//             line. Produces the synchronized level and one-cycle rise/fall
//             strobes. All flops reset to 1 (idle bus level).
//  Revision : 1.0 - initial release
// ============================================================================
module iic_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta_q;
    logic r_sync_q;
    logic r_dly_q;

    // Bring the pad level into the clock domain and keep one older sample
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta_q <= 1'b1;
            r_sync_q <= 1'b1;
            r_dly_q  <= 1'b1;
        end else begin
            r_meta_q <= i_d;
            r_sync_q <= r_meta_q;
            r_dly_q  <= r_sync_q;
        end
    end

    assign o_sync = r_sync_q;
    assign o_rise = r_sync_q & ~r_dly_q;
    assign o_fall = ~r_sync_q & r_dly_q;

endmodule : iic_edge_sync
`default_nettype wire

// File: rtl/iic_slave.sv
`default_nettype none
// ============================================================================
//  Module   : iic_slave
//  Purpose  : Byte-oriented I2C target. Oversamples SCL/SDA, detects
//             START/STOP, matches a 7-bit address, receives write bytes or
//             transmits read bytes with ACK/NACK handling. SDA is driven
//             open-drain through o_SDA_oe; the pad lives above this block.
//  Revision : 1.0 - initial release
// ============================================================================
module iic_slave
    import iic_slave_pkg::*;
#(
    parameter logic [6:0] ADDRESS = c_DEFAULT_ADDRESS
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_SCL,
    input  logic       i_SDA,
    output logic       o_SDA_oe,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_req,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_busy
);

    // ------------------------------------------------------------------
    // Synchronized bus view and events
    // ------------------------------------------------------------------
    logic w_scl;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda;
    logic w_sda_rise;
    logic w_sda_fall;
    logic w_start;
    logic w_stop;

    iic_edge_sync u_scl_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_SCL),
        .o_sync  (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    iic_edge_sync u_sda_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_SDA),
        .o_sync  (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    // SDA edges while SCL is high are bus conditions, not data
    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                   r_state_q;
    logic [c_BIT_CNT_W-1:0]   r_bit_cnt_q;
    logic                     r_byte_done_q;   // 8 bits shifted in, waiting for the ACK clock
    logic [7:0]               r_shift_q;       // receive shift register (address and write data)
    logic [7:0]               r_tx_q;          // transmit shift register, MSB is next bit to drive
    logic                     r_rw_q;          // R/W bit of the matched address byte
    logic                     r_sda_oe_q;
    logic                     r_tx_req_q;
    logic [7:0]               r_rx_byte_q;
    logic                     r_rx_valid_q;
    logic                     r_busy_q;

    // Protocol FSM: STOP, then START, override any coincident SCL edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q     <= ST_IDLE;
            r_bit_cnt_q   <= '0;
            r_byte_done_q <= 1'b0;
            r_shift_q     <= 8'h00;
            r_tx_q        <= 8'h00;
            r_rw_q        <= 1'b0;
            r_sda_oe_q    <= c_OE_RELEASE;
            r_tx_req_q    <= 1'b0;
            r_rx_byte_q   <= 8'h00;
            r_rx_valid_q  <= 1'b0;
            r_busy_q      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            r_tx_req_q   <= 1'b0;
            r_rx_valid_q <= 1'b0;

            if (w_stop) begin
                r_state_q     <= ST_IDLE;
                r_sda_oe_q    <= c_OE_RELEASE;
                r_busy_q      <= 1'b0;
                r_byte_done_q <= 1'b0;
            end else if (w_start) begin
                // Covers both a fresh START and a repeated START
                r_state_q     <= ST_ADDR;
                r_bit_cnt_q   <= '0;
                r_byte_done_q <= 1'b0;
                r_sda_oe_q    <= c_OE_RELEASE;
                r_busy_q      <= 1'b0;
            end else begin
                unique case (r_state_q)
                    ST_IDLE: begin
                        // Nothing to do until a START appears
                    end

                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift_q   <= {r_shift_q[6:0], w_sda};
                            r_bit_cnt_q <= r_bit_cnt_q + 3'd1;
                            if (r_bit_cnt_q == c_LAST_BIT) begin
                                r_byte_done_q <= 1'b1;
                            end
                        end else if (w_scl_fall && r_byte_done_q) begin
                            // Falling edge after bit 8 opens the ACK clock
                            r_byte_done_q <= 1'b0;
                            if (addr_match(r_shift_q, ADDRESS)) begin
                                r_state_q  <= ST_ADDR_ACK;
                                r_rw_q     <= r_shift_q[0];
                                r_sda_oe_q <= c_OE_PULL;
                                r_busy_q   <= 1'b1;
                            end else begin
                                r_state_q  <= ST_WAIT_STOP;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt_q <= '0;
                            if (r_rw_q) begin
                                // Read: first data bit goes out right away
                                r_state_q  <= ST_TX;
                                r_tx_q     <= i_tx_byte;
                                r_tx_req_q <= 1'b1;
                                r_sda_oe_q <= ~i_tx_byte[7];
                            end else begin
                                r_state_q  <= ST_RX;
                                r_sda_oe_q <= c_OE_RELEASE;
                            end
                        end
                    end

                    ST_RX: begin
                        if (w_scl_rise) begin
                            r_shift_q   <= {r_shift_q[6:0], w_sda};
                            r_bit_cnt_q <= r_bit_cnt_q + 3'd1;
                            if (r_bit_cnt_q == c_LAST_BIT) begin
                                r_rx_byte_q   <= {r_shift_q[6:0], w_sda};
                                r_rx_valid_q  <= 1'b1;
                                r_byte_done_q <= 1'b1;
                            end
                        end else if (w_scl_fall && r_byte_done_q) begin
                            r_byte_done_q <= 1'b0;
                            r_state_q     <= ST_RX_ACK;
                            r_sda_oe_q    <= c_OE_PULL;
                        end
                    end

                    ST_RX_ACK: begin
                        if (w_scl_fall) begin
                            r_state_q   <= ST_RX;
                            r_sda_oe_q  <= c_OE_RELEASE;
                            r_bit_cnt_q <= '0;
                        end
                    end

                    ST_TX: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt_q == c_LAST_BIT) begin
                                // Bit 0 clock finished: let the master answer
                                r_state_q  <= ST_TX_ACK;
                                r_sda_oe_q <= c_OE_RELEASE;
                            end else begin
                                r_sda_oe_q  <= ~r_tx_q[6];
                                r_tx_q      <= {r_tx_q[6:0], 1'b0};
                                r_bit_cnt_q <= r_bit_cnt_q + 3'd1;
                            end
                        end
                    end

                    ST_TX_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == c_NACK) begin
                                r_state_q  <= ST_WAIT_STOP;
                                r_sda_oe_q <= c_OE_RELEASE;
                            end
                        end else if (w_scl_fall) begin
                            // Master acknowledged: fetch and start the next byte
                            r_state_q   <= ST_TX;
                            r_bit_cnt_q <= '0;
                            r_tx_q      <= i_tx_byte;
                            r_tx_req_q  <= 1'b1;
                            r_sda_oe_q  <= ~i_tx_byte[7];
                        end
                    end

                    ST_WAIT_STOP: begin
                        // Bus traffic ignored; only START/STOP leave this state
                    end

                    default: begin
                        r_state_q  <= ST_IDLE;
                        r_sda_oe_q <= c_OE_RELEASE;
                    end
                endcase
            end
        end
    end

    assign o_SDA_oe   = r_sda_oe_q;
    assign o_tx_req   = r_tx_req_q;
    assign o_rx_byte  = r_rx_byte_q;
    assign o_rx_valid = r_rx_valid_q;
    assign o_busy     = r_busy_q;

endmodule : iic_slave
`default_nettype wire

// File: tb/tb_iic_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iic_slave
//  Purpose  : Self-checking bench for iic_slave. A bus-master model drives
//             SCL/SDA; expected receive bytes, transmit requests and
//             target-driven SDA bits are queued by the stimulus and popped
//             by independent monitors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iic_slave;

    localparam int Q = 10;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic [7:0] tx_byte = 8'h00;
    logic       sda_oe;
    logic       tx_req;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_txreq_q[$];
    logic [7:0] tx_next_q[$];
    logic       exp_bit_q[$];
    logic       chk_slot = 1'b0;
    string      slot_name = "";
    logic       watch_idle = 1'b0;
    int         oe_viol = 0;
    int         busy_viol = 0;

    // Open-drain bus with pull-up
    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    iic_slave dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_SCL      (scl_m),
        .i_SDA      (sda_bus),
        .o_SDA_oe   (sda_oe),
        .i_tx_byte  (tx_byte),
        .o_tx_req   (tx_req),
        .o_rx_byte  (rx_byte),
        .o_rx_valid (rx_valid),
        .o_busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops expected bytes whenever the DUT strobes
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && tx_req) check("pulse_overlap", 32'd1, 32'd0);
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) check("rx_unexpected", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                else check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_rx_q.pop_front()});
            end
            if (tx_req) begin
                if (exp_txreq_q.size() == 0) check("txreq_unexpected", {24'd0, tx_byte}, 32'hFFFF_FFFF);
                else begin
                    check("tx_req_byte", {24'd0, tx_byte}, {24'd0, exp_txreq_q.pop_front()});
                    if (tx_next_q.size() != 0) tx_byte = tx_next_q.pop_front();
                end
            end
            if (watch_idle && sda_oe) oe_viol++;
            if (watch_idle && busy)   busy_viol++;
        end
    end

    // Bit monitor: master samples SDA on its own SCL rise during target-driven slots
    always @(posedge scl_m) begin
        if (chk_slot) begin
            if (exp_bit_q.size() == 0) check({slot_name, "_unqueued"}, {31'd0, sda_bus}, 32'hFFFF_FFFF);
            else check(slot_name, {31'd0, sda_bus}, {31'd0, exp_bit_q.pop_front()});
        end
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        wq(); sda_m = b; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0;
    endtask

    // Slot where the target drives SDA; master releases and samples
    task automatic dut_slot(input logic exp, input string nm);
        wq(); sda_m = 1'b1; wq();
        exp_bit_q.push_back(exp);
        slot_name = nm;
        chk_slot  = 1'b1;
        scl_m     = 1'b1;
        wq(); wq();
        chk_slot  = 1'b0;
        scl_m     = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        dut_slot(exp_ack, nm);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic master_ack);
        for (int i = 7; i >= 0; i--) dut_slot(exp[i], "read_bit");
        send_bit(master_ack);
    endtask

    task automatic bus_start();
        wq(); sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wq(); sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_oe",       {31'd0, sda_oe},   32'd0);
        check("rst_tx_req",   {31'd0, tx_req},   32'd0);
        check("rst_rx_byte",  {24'd0, rx_byte},  32'h00);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write 0xA5 to address 0x4F
        bus_start();
        write_byte(8'h9E, 1'b0, "addr_ack_w");
        check("busy_after_match", {31'd0, busy}, 32'd1);
        exp_rx_q.push_back(8'hA5);
        write_byte(8'hA5, 1'b0, "data_ack_w");
        bus_stop();
        repeat (10) @(negedge clk);
        check("busy_after_stop", {31'd0, busy},   32'd0);
        check("oe_after_stop",   {31'd0, sda_oe}, 32'd0);

        // Read 0x3C (ACK) then 0xC3 (NACK)
        tx_byte = 8'h3C;
        tx_next_q.push_back(8'hC3);
        exp_txreq_q.push_back(8'h3C);
        exp_txreq_q.push_back(8'hC3);
        bus_start();
        write_byte(8'h9F, 1'b0, "addr_ack_r");
        read_byte(8'h3C, 1'b0);
        read_byte(8'hC3, 1'b1);
        wq();
        check("oe_after_nack", {31'd0, sda_oe}, 32'd0);
        bus_stop();
        repeat (10) @(negedge clk);

        // Foreign address: never acknowledged, never busy
        oe_viol = 0; busy_viol = 0; watch_idle = 1'b1;
        bus_start();
        write_byte(8'hA0, 1'b1, "addr_nack");
        write_byte(8'h55, 1'b1, "ignored_byte");
        bus_stop();
        repeat (10) @(negedge clk);
        watch_idle = 1'b0;
        check("mismatch_oe_cycles",   oe_viol,   32'd0);
        check("mismatch_busy_cycles", busy_viol, 32'd0);

        // Write 0x11, repeated START, read 0x5A
        bus_start();
        write_byte(8'h9E, 1'b0, "addr_ack_w2");
        exp_rx_q.push_back(8'h11);
        write_byte(8'h11, 1'b0, "data_ack_w2");
        tx_byte = 8'h5A;
        exp_txreq_q.push_back(8'h5A);
        bus_start();
        write_byte(8'h9F, 1'b0, "addr_ack_sr");
        check("busy_after_sr", {31'd0, busy}, 32'd1);
        check("rx_hold_sr", {24'd0, rx_byte}, 32'h11);
        read_byte(8'h5A, 1'b1);
        bus_stop();
        repeat (10) @(negedge clk);

        // Reset while the target holds the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(logic'(8'h9E >> i));
        wq(); sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        check("oe_in_ack", {31'd0, sda_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("oe_async_reset",   {31'd0, sda_oe}, 32'd0);
        check("busy_async_reset", {31'd0, busy},   32'd0);
        @(negedge clk);
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        bus_start();
        write_byte(8'h9E, 1'b0, "addr_ack_post_rst");
        exp_rx_q.push_back(8'h77);
        write_byte(8'h77, 1'b0, "data_ack_post_rst");
        bus_stop();
        repeat (10) @(negedge clk);
        check("busy_end", {31'd0, busy}, 32'd0);

        check("rx_left",    exp_rx_q.size(),    32'd0);
        check("txreq_left", exp_txreq_q.size(), 32'd0);
        check("bits_left",  exp_bit_q.size(),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog against a stuck run
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule : tb_iic_slave
`default_nettype wire
